bcd_autoscale: RTL and testbench
================================

// Module: bcd_autoscale
// PURPOSE
//  Downstream stage of the divider in the auto-scaled low-frequency counter.
//  Takes the binary quotient (frequency) produced by the divider and converts
//  it to BCD with an iterative double-dabble engine (one bit per clock).
//  It then auto-scales the result to the 4 most significant digits plus a
//  decimal exponent. The display mux consumes the 4 digits and the exponent.
// PARAMETERS
//  N       32  width of binary input; matches divider quotient width
//  DIGITS  10  BCD digits in conversion register; 10**DIGITS > 2**N required
//  EW      $clog2(DIGITS-3)  width of exp_o (3 for DIGITS=10)
// PORTS
//  clk_i      in   1       single clock, all logic on rising edge
//  reset_i    in   1       synchronous, active-low reset
//  start_i    in   1       request conversion; sampled only when ready_o=1
//  binary_i   in   N       unsigned value; captured on the accepting edge
//  ready_o    out  1       high while in IDLE (can accept start_i)
//  done_o     out  1       one-cycle pulse: outputs valid from this cycle
//  bcd3_o     out  4       most significant displayed digit
//  bcd2_o     out  4       displayed digit
//  bcd1_o     out  4       displayed digit
//  bcd0_o     out  4       least significant displayed digit
//  exp_o      out  EW      digits dropped right of bcd0_o (value ~ d3d2d1d0*10**exp_o)
// BEHAVIOUR
//  Reset (reset_i=0 at a clock edge):
//   - state=IDLE; ready_o=1; done_o=0.
//   - bcd3..0_o=0; exp_o=0; internal regs cleared.
//   - Reset mid-conversion aborts the conversion; no done_o pulse is produced.
//  States:
//   - IDLE: ready_o=1. If start_i=1, capture binary_i into the shift register,
//     clear the BCD register (4*DIGITS) and shift count s, then go to CONVERT.
//   - CONVERT: exactly N cycles. Each cycle, for every digit >=5 add 3, then
//     shift {bcd,bin} left 1 bit with the binary MSB entering the BCD LSB. After
//     the Nth shift, go to SCALE.
//   - SCALE: each cycle, if the top digit !=0 or s==DIGITS-4, register outputs
//     and go to DONE. Otherwise shift the BCD register left one digit (4 bits,
//     zero fill) and increment s.
//      bcd3_o..bcd0_o = top 4 digits
//      exp_o          = DIGITS-4-s
//   - DONE: done_o=1 for exactly this cycle; ready_o=0; next state is IDLE.
//  Latency: done_o is high after N+s+1 rising edges counted from the edge that
//   samples start_i, where s = leading-zero digits, capped at DIGITS-4.
//   For N=32, DIGITS=10, the range is 33..39 edges.
//  start_i is ignored in CONVERT, SCALE and DONE (no queueing).
//  Outputs hold their last values until the next entry into DONE or a reset.
//  Input 0: s reaches DIGITS-4, so digits are 0000 and exp_o=0.
//  Values <10000: shown exactly, exp_o=0, leading zeros kept (42 -> 0,0,4,2).
//  Lower digits are truncated, not rounded.
// TESTING
//  1. Hold reset_i=0 for 4 cycles -> ready_o=1, done_o=0, all digits 0, exp_o=0.
//  2. start_i=1 for one cycle, binary_i=1234567 -> after 36 edges done_o pulses
//     one cycle; digits 1,2,3,4; exp_o=3; ready_o returns to 1 next cycle.
//  3. binary_i=42 -> done_o after 39 edges; digits 0,0,4,2; exp_o=0.
//     binary_i=0 -> digits 0,0,0,0; exp_o=0.
//  4. binary_i=32'hFFFFFFFF (4294967295) -> done_o after 33 edges;
//     digits 4,2,9,4; exp_o=6.
//  5. Start with 500000, then pulse start_i again with 7 while busy -> the
//     second start is ignored; result is digits 5,0,0,0 with exp_o=2; outputs
//     then hold through 10 idle cycles.
//  6. Drive reset_i=0 for one cycle at edge 20 of a conversion -> no done_o
//     pulse, outputs 0, ready_o=1. A new start with 9999 then gives
//     digits 9,9,9,9 and exp_o=0.

Source files
------------

// File: rtl/bcd_autoscale.sv
// Binary-to-BCD converter (double-dabble, one bit per clock) that auto-scales the result to 4 digits plus a decimal exponent.
// Latency: done_o is high N+s+1 edges after the start edge, where s = leading-zero digits capped at DIGITS-4.
// Backpressure: none; start_i is accepted only while ready_o=1, and a start at any other time is dropped.
module bcd_autoscale #(
    parameter int N      = 32,
    parameter int DIGITS = 10,
    parameter int EW     = $clog2(DIGITS-3)
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          start_i,
    input  logic [N-1:0]  binary_i,
    output logic          ready_o,
    output logic          done_o,
    output logic [3:0]    bcd3_o,
    output logic [3:0]    bcd2_o,
    output logic [3:0]    bcd1_o,
    output logic [3:0]    bcd0_o,
    output logic [EW-1:0] exp_o
);

    localparam int BW = 4*DIGITS;
    localparam int CW = $clog2(N+1);
    // s stops at this value; it is also the exponent when s is zero
    localparam logic [EW-1:0] SMAX = EW'(DIGITS-4);
    localparam logic [CW-1:0] LAST = CW'(N-1);

    typedef enum logic [1:0] {IDLE, CONVERT, SCALE, DONE} state_t;

    state_t        state;
    logic [N-1:0]  bin;
    logic [BW-1:0] bcd;
    logic [BW-1:0] bcd_adj;
    logic [CW-1:0] cnt;
    logic [EW-1:0] s;

    // Double-dabble correction: add 3 to every digit of 5 or more before the shift
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    // Control FSM: convert, then normalise the digits, with registered handshake and result outputs
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state   <= IDLE;
            ready_o <= 1'b1;
            done_o  <= 1'b0;
            bin     <= '0;
            bcd     <= '0;
            cnt     <= '0;
            s       <= '0;
            bcd3_o  <= '0;
            bcd2_o  <= '0;
            bcd1_o  <= '0;
            bcd0_o  <= '0;
            exp_o   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        bin     <= binary_i;
                        bcd     <= '0;
                        cnt     <= '0;
                        s       <= '0;
                        ready_o <= 1'b0;
                        state   <= CONVERT;
                    end
                end
                CONVERT: begin
                    // The binary MSB enters the BCD LSB
                    bcd <= {bcd_adj[BW-2:0], bin[N-1]};
                    bin <= {bin[N-2:0], 1'b0};
                    cnt <= cnt + CW'(1);
                    if (cnt == LAST)
                        state <= SCALE;
                end
                SCALE: begin
                    // Stop on a nonzero top digit, or at the cap so that small values keep their leading zeros
                    if (bcd[BW-1 -: 4] != 4'd0 || s == SMAX) begin
                        bcd3_o <= bcd[BW-1  -: 4];
                        bcd2_o <= bcd[BW-5  -: 4];
                        bcd1_o <= bcd[BW-9  -: 4];
                        bcd0_o <= bcd[BW-13 -: 4];
                        exp_o  <= SMAX - s;
                        done_o <= 1'b1;
                        state  <= DONE;
                    end else begin
                        bcd <= {bcd[BW-5:0], 4'd0};
                        s   <= s + EW'(1);
                    end
                end
                DONE: begin
                    done_o  <= 1'b0;
                    ready_o <= 1'b1;
                    state   <= IDLE;
                end
                default: begin
                    state   <= IDLE;
                    ready_o <= 1'b1;
                    done_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_autoscale.sv
// Bench for bcd_autoscale: directed conversions with hand-computed digits, exponent and latency.
// Stimulus pushes the expected result into a queue, and a separate monitor compares on each done_o pulse.
// Also checks reset state, the ignored start while busy, output hold, and abort by reset.
module tb_bcd_autoscale;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        start_i;
    logic [31:0] binary_i;
    logic        ready_o;
    logic        done_o;
    logic [3:0]  bcd3_o, bcd2_o, bcd1_o, bcd0_o;
    logic [2:0]  exp_o;

    typedef struct {
        logic [15:0] digits;
        logic [2:0]  expo;
        int          lat;
        int          start_cyc;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;

    bcd_autoscale #(.N(32), .DIGITS(10)) dut (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .start_i  (start_i),
        .binary_i (binary_i),
        .ready_o  (ready_o),
        .done_o   (done_o),
        .bcd3_o   (bcd3_o),
        .bcd2_o   (bcd2_o),
        .bcd1_o   (bcd1_o),
        .bcd0_o   (bcd0_o),
        .exp_o    (exp_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, req, req);
        end
    endtask

    function automatic logic [15:0] digits_now();
        return {bcd3_o, bcd2_o, bcd1_o, bcd0_o};
    endfunction

    // Monitor: every done_o pulse must match the oldest expectation in the queue
    always @(negedge clk_i) begin
        if (reset_i === 1'b1 && done_o === 1'b1) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_done: got done_o=1 at cycle %0d expected no pulse", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("digits", 32'(digits_now()), 32'(e.digits));
                chk("exp", 32'(exp_o), 32'(e.expo));
                chk("latency", 32'(cyc - e.start_cyc), 32'(e.lat));
            end
        end
    end

    // Start a conversion at the next edge and queue its expected result
    task automatic issue(input logic [31:0] v, input logic [15:0] d, input logic [2:0] ex, input int lat);
        exp_t e;
        int   k;
        k = 0;
        while (ready_o !== 1'b1 && k < 60) begin
            @(negedge clk_i);
            k++;
        end
        chk("ready_before_start", 32'(ready_o), 32'd1);
        start_i   = 1'b1;
        binary_i  = v;
        e.digits    = d;
        e.expo      = ex;
        e.lat       = lat;
        e.start_cyc = cyc + 1;
        sb.push_back(e);
        @(negedge clk_i);
        start_i  = 1'b0;
        binary_i = 32'hDEAD_BEEF;
    endtask

    // Wait (bounded) for done_o, then check the pulse width and the ready handshake
    task automatic wait_done(input string name);
        bit got;
        got = 1'b0;
        repeat (80) begin
            if (done_o === 1'b1) begin
                got = 1'b1;
                break;
            end
            @(negedge clk_i);
        end
        if (!got) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_timeout: got no done_o within 80 cycles expected a pulse", name);
            sb.delete();
        end else begin
            chk("ready_during_done", 32'(ready_o), 32'd0);
            @(negedge clk_i);
            chk("done_one_cycle", 32'(done_o), 32'd0);
            chk("ready_after_done", 32'(ready_o), 32'd1);
        end
    endtask

    initial begin
        logic [15:0] held_d;
        logic [2:0]  held_e;
        reset_i  = 1'b0;
        start_i  = 1'b0;
        binary_i = '0;

        // Reset state
        repeat (4) @(negedge clk_i);
        chk("rst_ready", 32'(ready_o), 32'd1);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_digits", 32'(digits_now()), 32'd0);
        chk("rst_exp", 32'(exp_o), 32'd0);
        reset_i = 1'b1;
        @(negedge clk_i);

        // 1234567 -> 1234 e3; s=3 so 32+3+1 edges
        issue(32'd1234567, 16'h1234, 3'd3, 36);
        wait_done("v1234567");
        // 42 -> 0042 e0; s capped at 6
        issue(32'd42, 16'h0042, 3'd0, 39);
        wait_done("v42");
        // 0 -> 0000 e0
        issue(32'd0, 16'h0000, 3'd0, 39);
        wait_done("v0");
        // Full scale 4294967295 -> 4294 e6; no scaling shifts
        issue(32'hFFFF_FFFF, 16'h4294, 3'd6, 33);
        wait_done("vmax");
        // 10000 -> 1000 e1 (truncated, just above the exact range)
        issue(32'd10000, 16'h1000, 3'd1, 38);
        wait_done("v10000");

        // 500000 -> 5000 e2, with a second start while busy that must be dropped
        issue(32'd500000, 16'h5000, 3'd2, 37);
        repeat (5) @(negedge clk_i);
        chk("ready_busy", 32'(ready_o), 32'd0);
        start_i  = 1'b1;
        binary_i = 32'd7;
        @(negedge clk_i);
        start_i  = 1'b0;
        wait_done("v500000");
        held_d = 16'h5000;
        held_e = 3'd2;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            chk("hold", 32'({digits_now(), 1'b0, exp_o}), 32'({held_d, 1'b0, held_e}));
        end

        // Reset at edge 20 of a conversion: no pulse, outputs cleared
        issue(32'd1234567, 16'h0, 3'd0, 0);
        void'(sb.pop_back());
        repeat (18) @(negedge clk_i);
        reset_i = 1'b0;
        @(negedge clk_i);
        reset_i = 1'b1;
        chk("abort_ready", 32'(ready_o), 32'd1);
        chk("abort_done", 32'(done_o), 32'd0);
        chk("abort_digits", 32'(digits_now()), 32'd0);
        chk("abort_exp", 32'(exp_o), 32'd0);
        repeat (30) @(negedge clk_i);
        chk("abort_still_idle", 32'({ready_o, done_o}), 32'b10);

        // 9999 -> 9999 e0
        issue(32'd9999, 16'h9999, 3'd0, 39);
        wait_done("v9999");

        repeat (3) @(negedge clk_i);
        if (sb.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL leftover: got %0d pending results expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
